// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, start-bit glitch rejection,
// parity/framing flags and a valid/ready output FIFO.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 65000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t               state, state_nx;
  logic                 sync1, sync2;
  logic [2:0]           hist;
  logic                 bit_val, sample;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [3:0]           nbit, nbit_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 perr, perr_nx, ferr, ferr_nx;
  logic                 push_req;
  logic [EW-1:0]        push_word;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;

  // hist shifts in sync1 so that hist[0] tracks sync2: the vote always covers
  // the three most recent synchronized samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= '1;
    end else begin
      sync1 <= uart_rx_i;
      sync2 <= sync1;
      hist  <= {hist[1:0], sync1};
    end
  end

  assign bit_val = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign sample  = (cnt == FULL_M1);

  always_comb begin
    state_nx  = state;
    cnt_nx    = sample ? '0 : cnt + CW'(1);
    nbit_nx   = nbit;
    shreg_nx  = shreg;
    perr_nx   = perr;
    ferr_nx   = ferr;
    push_req  = 1'b0;
    push_word = {ferr | ~bit_val, perr, shreg};
    case (state)
      ST_IDLE: begin
        cnt_nx  = '0;
        nbit_nx = '0;
        if (!sync2) state_nx = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_M1) begin
          cnt_nx = '0;
          if (bit_val) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_DATA;
            perr_nx  = 1'b0;
            ferr_nx  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shreg_nx = {bit_val, shreg[DATA_BITS-1:1]};
          if (nbit == 4'(DATA_BITS - 1)) begin
            nbit_nx  = '0;
            state_nx = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            nbit_nx = nbit + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          perr_nx  = (^shreg) ^ bit_val ^ (PARITY == 2);
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          if (!bit_val) ferr_nx = 1'b1;
          if (nbit == 4'(STOP_BITS - 1)) begin
            push_req = 1'b1;
            nbit_nx  = '0;
            state_nx = ST_IDLE;
          end else begin
            nbit_nx = nbit + 4'd1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      nbit  <= '0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      nbit  <= nbit_nx;
      shreg <= shreg_nx;
      perr  <= perr_nx;
      ferr  <= ferr_nx;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = push_req && (!full || pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_o <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_word;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      overrun_o <= push_req && full && !pop;
    end
  end

  assign {frame_err_o, parity_err_o, data_o} = mem[rd_ptr[AW-1:0]];
  assign valid_o = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: four instances (8N1, 8E1, 8O1, 7E2) at 16 clocks
// per bit, checked each cycle against a frame-level FIFO model.
module tb_uart_rx_fifo;
  localparam int DBS  [4] = '{8, 8, 8, 7};
  localparam int PARS [4] = '{0, 1, 2, 1};
  localparam int SBS  [4] = '{1, 1, 1, 2};
  localparam int DEPTH = 4;
  localparam logic [10:0] EXP0 [9] = '{11'h055, 11'h0A3, 11'h43C, 11'h081, 11'h000,
                                      11'h010, 11'h011, 11'h012, 11'h013};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rx = '1, ready = '1;
  logic [3:0] valid, ovr, fe, pe;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [10:0] word [4];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk_i(clk), .rst_i(rst), .uart_rx_i(rx[0]), .data_o(d0), .parity_err_o(pe[0]),
    .frame_err_o(fe[0]), .valid_o(valid[0]), .ready_i(ready[0]), .overrun_o(ovr[0]));
  uart_rx_fifo #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk_i(clk), .rst_i(rst), .uart_rx_i(rx[1]), .data_o(d1), .parity_err_o(pe[1]),
    .frame_err_o(fe[1]), .valid_o(valid[1]), .ready_i(ready[1]), .overrun_o(ovr[1]));
  uart_rx_fifo #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk_i(clk), .rst_i(rst), .uart_rx_i(rx[2]), .data_o(d2), .parity_err_o(pe[2]),
    .frame_err_o(fe[2]), .valid_o(valid[2]), .ready_i(ready[2]), .overrun_o(ovr[2]));
  uart_rx_fifo #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk_i(clk), .rst_i(rst), .uart_rx_i(rx[3]), .data_o(d3), .parity_err_o(pe[3]),
    .frame_err_o(fe[3]), .valid_o(valid[3]), .ready_i(ready[3]), .overrun_o(ovr[3]));

  assign word[0] = {fe[0], pe[0], 1'b0, d0};
  assign word[1] = {fe[1], pe[1], 1'b0, d1};
  assign word[2] = {fe[2], pe[2], 1'b0, d2};
  assign word[3] = {fe[3], pe[3], 2'b00, d3};

  // Frame requests from the stimulus: cycle at which the word must enter the FIFO.
  int          req_at [4] = '{-1, -1, -1, -1};
  logic [10:0] req_w  [4];

  // Model: expected FIFO contents per instance.
  int          cyc = 0;
  logic [10:0] mq [4][8];
  int          mcnt [4] = '{0, 0, 0, 0};
  logic [3:0]  exp_ovr = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
      exp_ovr = '0;
    end else begin
      cyc++;
      for (int i = 0; i < 4; i++) begin
        exp_ovr[i] = 1'b0;
        if (mcnt[i] > 0 && ready[i]) begin
          for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
          mcnt[i]--;
        end
        if (cyc == req_at[i]) begin
          if (mcnt[i] < DEPTH) begin
            mq[i][mcnt[i]] = req_w[i];
            mcnt[i]++;
          end else begin
            exp_ovr[i] = 1'b1;
          end
        end
      end
    end
  end

  // Compare process and literal end-of-run checks.
  int          checks = 0, errors = 0;
  logic [10:0] logw [4][16];
  int          lc [4]   = '{0, 0, 0, 0};
  int          ocnt [4] = '{0, 0, 0, 0};
  logic        final_req = 1'b0, final_done = 1'b0;
  logic        snap_pre = 1'b0, snap_rst_valid = 1'b1;
  logic [6:0]  snap_rst_data = '1;
  logic [15:0] snap_init = '1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("valid%0d@%0d", i, cyc), 32'(valid[i]), 32'(mcnt[i] != 0));
        if (mcnt[i] != 0) chk($sformatf("word%0d@%0d", i, cyc), 32'(word[i]), 32'(mq[i][0]));
        chk($sformatf("overrun%0d@%0d", i, cyc), 32'(ovr[i]), 32'(exp_ovr[i]));
        if (valid[i] && ready[i] && lc[i] < 16) begin
          logw[i][lc[i]] = word[i];
          lc[i]++;
        end
        if (ovr[i]) ocnt[i]++;
      end
    end
    if (final_req && !final_done) begin
      final_done = 1'b1;
      chk("reset_state", 32'(snap_init), 32'h0);
      chk("log0_count", 32'(lc[0]), 32'd9);
      for (int k = 0; k < 9; k++) chk($sformatf("log0_%0d", k), 32'(logw[0][k]), 32'(EXP0[k]));
      for (int i = 1; i < 3; i++) begin
        chk($sformatf("log%0d_count", i), 32'(lc[i]), 32'd2);
        chk($sformatf("log%0d_good_parity", i), 32'(logw[i][0]), 32'h007);
        chk($sformatf("log%0d_bad_parity", i), 32'(logw[i][1]), 32'h207);
      end
      chk("log3_count", 32'(lc[3]), 32'd1);
      chk("log3_after_reset", 32'(logw[3][0]), 32'h05A);
      chk("overrun_pulses0", 32'(ocnt[0]), 32'd1);
      chk("overrun_pulses_others", 32'(ocnt[1] + ocnt[2] + ocnt[3]), 32'd0);
      chk("pre_reset_valid3", 32'(snap_pre), 32'd1);
      chk("async_reset_valid3", 32'(snap_rst_valid), 32'd0);
      chk("async_reset_data3", 32'(snap_rst_data), 32'd0);
    end
  end

  // Stimulus: every step leaves time at 1 unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [8:0] dat, input bit flip, input bit stop_low,
                      input int cut, input int spike);
    int          db, hp, n;
    logic [15:0] bits;
    logic        p;
    bit          done;
    db = DBS[i];
    hp = (PARS[i] != 0) ? 1 : 0;
    n  = db + hp + SBS[i];
    bits = '1;
    bits[0] = 1'b0;
    p = 1'b0;
    for (int k = 0; k < db; k++) begin
      bits[k+1] = dat[k];
      p ^= dat[k];
    end
    if (PARS[i] == 2) p = ~p;
    if (hp != 0) bits[db+1] = p ^ flip;
    if (stop_low) bits[db+1+hp] = 1'b0;
    if (cut < 0) begin
      // 3 cycles to enter START, CPB/2 to confirm it, then CPB per sampled bit.
      req_at[i] = cyc + 11 + 16 * n;
      req_w[i]  = {stop_low, flip && (hp != 0), dat & 9'((1 << db) - 1)};
    end
    done = 1'b0;
    for (int t = 0; t < 16 * (n + 1) && !done; t++) begin
      if (t == cut) begin
        done = 1'b1;
      end else begin
        rx[i] = bits[t/16] ^ (t == spike);
        step(1);
      end
    end
    rx[i] = 1'b1;
  endtask

  task automatic low_pulse(input int i, input int len);
    rx[i] = 1'b0;
    step(len);
    rx[i] = 1'b1;
    step(60);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    snap_init = {valid, ovr, d0};
    step(5);
    send(0, 9'h55, 0, 0, -1, -1);
    send(0, 9'hA3, 0, 0, -1, -1);
    step(20);
    for (int i = 1; i < 3; i++) begin
      send(i, 9'h07, 0, 0, -1, -1);
      step(10);
      send(i, 9'h07, 1, 0, -1, -1);
      step(20);
    end
    send(0, 9'h3C, 0, 1, -1, -1);
    step(30);
    send(0, 9'h81, 0, 0, -1, -1);
    step(20);
    low_pulse(0, 5);
    low_pulse(1, 7);
    send(0, 9'h00, 0, 0, -1, 56);
    step(20);
    ready[0] = 1'b0;
    for (int k = 0; k < 5; k++) send(0, 9'(8'h10 + k), 0, 0, -1, -1);
    step(5);
    ready[0] = 1'b1;
    step(20);
    ready[3] = 1'b0;
    send(3, 9'h11, 0, 0, -1, -1);
    send(3, 9'h22, 0, 0, -1, -1);
    step(5);
    snap_pre = valid[3];
    send(3, 9'h33, 0, 0, 70, -1);
    rst = 1'b1;
    #1;
    snap_rst_valid = valid[3];
    snap_rst_data  = d3;
    #1;
    rst = 1'b0;
    step(1);
    ready[3] = 1'b1;
    step(20);
    send(3, 9'h5A, 0, 0, -1, -1);
    step(20);
    final_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with configurable frame format, start-bit glitch rejection, 3-sample majority voting, per-word parity/framing error flags and an output FIFO with valid/ready handshake. It sits between the serial input pin and the character/command consumers of the VGA controller. It replaces single-cycle write strobes with a buffered stream, so a busy consumer does not lose bytes.

## Interface
Parameters:
- CLK_FREQ, 65000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate. CPB = CLK_FREQ/BAUD_RATE, integer truncation; CPB ≥ 8 required.
- DATA_BITS, 8: data bits per frame, legal 5..9, LSB first.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries, power of two ≥ 2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- uart_rx_i  in  1  asynchronous serial line, idle high.
- data_o  out  DATA_BITS  head-of-FIFO data.
- parity_err_o  out  1  head word had a parity mismatch; always 0 when PARITY=0.
- frame_err_o  out  1  head word had a low stop bit.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts the head word when valid_o&ready_i.
- overrun_o  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.

## Operation
- Input path: 2-FF synchronizer, both FFs reset to 1. A 3-bit history shift register holds the last three synchronized samples. The bit value is the majority of those three samples.
- Baud counter: width $clog2(CPB). It is held at 0 in IDLE and wraps at CPB-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: synchronized rx = 0 -> START, counter cleared.
  - START: at count CPB/2-1, majority 1 -> IDLE (glitch rejected, no flags, no push); majority 0 -> DATA, counter cleared. Every later sample point is the counter reaching CPB-1, i.e. mid-bit.
  - DATA: at each sample point, shift the majority bit in at the MSB of the shift register (LSB first on the line). After DATA_BITS samples go to PARITY if PARITY≠0, else STOP.
  - PARITY: sample one bit. Error if the XOR of data and parity bit is 1 for even, or 0 for odd. -> STOP.
  - STOP: sample STOP_BITS bits. Any sample of 0 sets the framing error.
- Push: at the final stop sample the word and its flags are pushed to the FIFO and the FSM goes to IDLE in the same cycle. It does not wait for the end of the stop bit, so a back-to-back start bit is caught.
- A frame with a framing error is still pushed, with frame_err set.
- FIFO: circular buffer with $clog2(FIFO_DEPTH)+1-bit read/write pointers. Each entry is {frame_err, parity_err, data}.
  - Full when the pointers differ only in the MSB.
  - Empty when the pointers are equal.
  - Pointers wrap naturally.
- Outputs data_o, parity_err_o and frame_err_o are driven combinationally from the entry at the read pointer. They are only meaningful while valid_o=1.

## Timing
- Reset values: FSM IDLE; counters, pointers and shift register 0; valid_o=0; overrun_o=0. data_o, parity_err_o and frame_err_o read entry 0. Storage is not required to be reset, but must be 0 in simulation.
- Reset mid-frame discards the partial frame and all FIFO contents immediately, without waiting for a clock edge.
- Latency:
  - Line falling edge to START entry: 3 cycles (2 synchronizer cycles plus the IDLE decision).
  - Final stop sample to valid_o=1 (FIFO previously empty): 1 cycle.
- Handshake: the pop occurs on the clock edge where valid_o&ready_i. data_o may change only after a pop or after a push into an empty FIFO. ready_i while empty is ignored.
- Simultaneous push and pop:
  - Not full: both occur and the occupancy is unchanged.
  - Full: the push is accepted (the pop frees the slot) and overrun_o stays 0.
- Full without pop at push time: the frame is dropped, overrun_o=1 for exactly one cycle, and the FIFO is unchanged.
- A low pulse shorter than CPB/2 cycles never leaves START with a push.

## Test plan
Conditions: CLK_FREQ=16000000, BAUD_RATE=1000000 (CPB=16), ready_i=1 unless stated.
- 8N1: send 0x55 then 0xA3 back-to-back. Required: valid_o pulses twice, data_o=0x55 then 0xA3, no error flags, overrun_o never 1.
- 8E1 and 8O1: send 0x07 with correct parity, then with flipped parity. Required: parity_err_o=0 then 1, data_o=0x07 both times.
- Framing error: send 0x3C with the stop bit driven 0. Required: entry data_o=0x3C, frame_err_o=1. Return the line high, send 0x81: it is received clean.
- Glitch rejection and majority: a 5-cycle low pulse on an idle line gives no valid_o. A single-cycle inverted spike at the mid-bit of bit 2 of 0x00 still yields 0x00.
- Overflow: hold ready_i=0 and send 5 bytes 0x10..0x14 with FIFO_DEPTH=4. Required: one overrun_o pulse on the 5th frame. Then release ready_i: pops 0x10..0x13 in order, then valid_o=0.
- Reset mid-frame with FIFO holding 2 words and 7E2 framing (DATA_BITS=7, PARITY=1, STOP_BITS=2): assert rst_i during bit 3. Required: valid_o=0 at once. The next frame 0x5A is received correctly with no error flags.
